alu16_seq: RTL and testbench

- Sequential 16-bit two's-complement ALU for the processor datapath.
- Operands arrive serially on a shared input bus, and results leave serially on a shared output bus.
- Supports add, subtract, multiply (radix-2 Booth, 32-bit product) and divide (non-restoring, quotient plus remainder).
- The controller drives `start` and `s`, then waits for `finish`.

---
 rtl/alu16_pkg.sv | 30 +++
 rtl/alu16_iter_dp.sv | 86 ++++++++
 rtl/alu16_seq.sv | 195 +++++++++++++++++++
 tb/tb_alu16_seq.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu16_pkg.sv
// Shared opcodes, FSM states and datapath commands for the alu16_seq sequential ALU.
package alu16_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int ITERS = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    COMPUTE,
    ITER,
    CORRECT,
    OUT1,
    OUT2
  } state_e;

  typedef enum logic [2:0] {
    DP_HOLD,
    DP_LD_MUL,
    DP_LD_DIV,
    DP_BOOTH,
    DP_NRDIV,
    DP_FIX
  } dp_cmd_e;

endpackage

// File: rtl/alu16_iter_dp.sv
// Shared A/Q/M shift-register datapath: radix-2 Booth multiply steps and
// non-restoring divide steps on operand magnitudes, plus remainder correction.
module alu16_iter_dp
  import alu16_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic [2:0]   cmd_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] acc_o,
  output logic [W-1:0] q_o
);

  // Two guard bits keep both the Booth accumulator (M = -2^(W-1)) and the
  // shifted non-restoring partial remainder (|2A| up to 2^(W+1)) from wrapping.
  logic [W+1:0] acc_q;
  logic [W+1:0] m_q;
  logic [W-1:0] q_q;
  logic         q1_q;

  logic [W+1:0] booth_sum_d;
  logic [W+1:0] nr_shift_d;
  logic [W+1:0] nr_sum_d;
  logic [W-1:0] a_mag_d;
  logic [W-1:0] b_mag_d;

  always_comb begin
    booth_sum_d = acc_q;
    if ({q_q[0], q1_q} == 2'b01) begin
      booth_sum_d = acc_q + m_q;
    end else if ({q_q[0], q1_q} == 2'b10) begin
      booth_sum_d = acc_q - m_q;
    end
    nr_shift_d = {acc_q[W:0], q_q[W-1]};
    nr_sum_d   = acc_q[W+1] ? (nr_shift_d + m_q) : (nr_shift_d - m_q);
    a_mag_d    = a_i[W-1] ? (~a_i + 1'b1) : a_i;
    b_mag_d    = b_i[W-1] ? (~b_i + 1'b1) : b_i;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      acc_q <= '0;
      m_q   <= '0;
      q_q   <= '0;
      q1_q  <= 1'b0;
    end else begin
      case (cmd_i)
        DP_LD_MUL: begin
          acc_q <= '0;
          m_q   <= {{2{b_i[W-1]}}, b_i};
          q_q   <= a_i;
          q1_q  <= 1'b0;
        end
        DP_LD_DIV: begin
          acc_q <= '0;
          m_q   <= {2'b00, a_mag_d};
          q_q   <= b_mag_d;
          q1_q  <= 1'b0;
        end
        DP_BOOTH: begin
          acc_q <= {booth_sum_d[W+1], booth_sum_d[W+1:1]};
          q_q   <= {booth_sum_d[0], q_q[W-1:1]};
          q1_q  <= q_q[0];
        end
        DP_NRDIV: begin
          acc_q <= nr_sum_d;
          q_q   <= {q_q[W-2:0], ~nr_sum_d[W+1]};
        end
        DP_FIX: begin
          if (acc_q[W+1]) begin
            acc_q <= acc_q + m_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign acc_o = acc_q[W-1:0];
  assign q_o   = q_q;

endmodule

// File: rtl/alu16_seq.sv
// Sequential 16-bit ALU: serial operand load, add/sub/Booth mul/non-restoring div,
// serial result words. Define ALU_SAT_EN to saturate overflowing add/sub results.
module alu16_seq
  import alu16_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [1:0]   s,
  input  logic [W-1:0] inbus,
  output logic [W-1:0] outbus,
  output logic         finish,
  output logic         overflow
);

  localparam int            CW      = $clog2(ITERS);
  localparam logic [CW-1:0] LAST    = CW'(ITERS - 1);
  localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  r_q;
  logic          ovf_q;
  logic [W-1:0]  outbus_q;
  logic          finish_q;
  logic          overflow_q;

  logic [W-1:0]  as_raw_d;
  logic [W-1:0]  as_res_d;
  logic          as_ovf_d;
  logic [W-1:0]  dp_acc;
  logic [W-1:0]  dp_q;
  logic [W-1:0]  quot_d;
  logic [W-1:0]  rem_d;
  logic [W-1:0]  word1_d;
  logic [W-1:0]  word2_d;
  logic          ovf_d;
  logic          div_zero_d;
  logic          div_big_d;
  dp_cmd_e       dp_cmd;

  // Overflow direction always follows B's sign for both B+A and B-A.
  always_comb begin
    if (op_q == OP_SUB) begin
      as_raw_d = b_q - a_q;
      as_ovf_d = (b_q[W-1] != a_q[W-1]) && (as_raw_d[W-1] != b_q[W-1]);
    end else begin
      as_raw_d = b_q + a_q;
      as_ovf_d = (b_q[W-1] == a_q[W-1]) && (as_raw_d[W-1] != b_q[W-1]);
    end
    as_res_d = as_raw_d;
`ifdef ALU_SAT_EN
    if (as_ovf_d) begin
      as_res_d = b_q[W-1] ? MIN_NEG : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    div_zero_d = (a_q == '0);
    div_big_d  = (b_q == MIN_NEG) && (a_q == '1);
    quot_d     = (a_q[W-1] ^ b_q[W-1]) ? -dp_q : dp_q;
    rem_d      = b_q[W-1] ? -dp_acc : dp_acc;
    word1_d    = r_q;
    word2_d    = '0;
    ovf_d      = ovf_q;
    if (op_q == OP_MUL) begin
      word1_d = dp_acc;
      word2_d = dp_q;
      ovf_d   = 1'b0;
    end else if (op_q == OP_DIV) begin
      word1_d = quot_d;
      word2_d = rem_d;
      ovf_d   = div_zero_d | div_big_d;
      if (div_zero_d) begin
        word1_d = '1;
        word2_d = b_q;
      end
    end
  end

  always_comb begin
    dp_cmd = DP_HOLD;
    case (state_q)
      LOAD_B: begin
        if (op_q == OP_MUL) begin
          dp_cmd = DP_LD_MUL;
        end else if (op_q == OP_DIV) begin
          dp_cmd = DP_LD_DIV;
        end
      end
      ITER: begin
        if (op_q == OP_DIV) begin
          dp_cmd = DP_NRDIV;
        end else begin
          dp_cmd = DP_BOOTH;
        end
      end
      CORRECT: dp_cmd = DP_FIX;
      default: begin
      end
    endcase
  end

  alu16_iter_dp #(
    .W(W)
  ) u_dp (
    .clk  (clk),
    .rst_i(rst_b),
    .cmd_i(dp_cmd),
    .a_i  (a_q),
    .b_i  (inbus),
    .acc_o(dp_acc),
    .q_o  (dp_q)
  );

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      ovf_q      <= 1'b0;
      outbus_q   <= '0;
      finish_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      outbus_q <= '0;
      finish_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q       <= s;
            a_q        <= inbus;
            overflow_q <= 1'b0;
            state_q    <= LOAD_B;
          end
        end
        LOAD_B: begin
          b_q   <= inbus;
          cnt_q <= '0;
          if (op_q[1]) begin
            state_q <= ITER;
          end else begin
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          r_q     <= as_res_d;
          ovf_q   <= as_ovf_d;
          state_q <= OUT1;
        end
        ITER: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            if (op_q == OP_DIV) begin
              state_q <= CORRECT;
            end else begin
              state_q <= OUT1;
            end
          end
        end
        CORRECT: state_q <= OUT1;
        OUT1: begin
          outbus_q   <= word1_d;
          finish_q   <= 1'b1;
          overflow_q <= ovf_d;
          if (op_q[1]) begin
            state_q <= OUT2;
          end else begin
            state_q <= IDLE;
          end
        end
        OUT2: begin
          outbus_q <= word2_d;
          finish_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign outbus   = outbus_q;
  assign finish   = finish_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Scoreboard bench for alu16_seq: expected words are queued when an operation is
// driven and compared as the DUT presents each finish cycle.
module tb_alu16_seq;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start;
  logic [1:0]  s;
  logic [15:0] inbus;
  logic [15:0] outbus;
  logic        finish;
  logic        overflow;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [15:0] word;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  alu16_seq #(.W(16)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .start   (start),
    .s       (s),
    .inbus   (inbus),
    .outbus  (outbus),
    .finish  (finish),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic void push_expected(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    int     sa;
    int     sbv;
    int     r;
    longint p;
    exp_t   e;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    case (op)
      ADD, SUB: begin
        r      = (op == ADD) ? (sbv + sa) : (sbv - sa);
        e.ovf  = (r > 32767) || (r < -32768);
        e.word = r[15:0];
`ifdef ALU_SAT_EN
        if (e.ovf) e.word = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        sb.push_back(e);
      end
      MUL: begin
        p      = longint'(sa) * longint'(sbv);
        e.ovf  = 1'b0;
        e.word = p[31:16];
        sb.push_back(e);
        e.word = p[15:0];
        sb.push_back(e);
      end
      default: begin
        e.ovf = 1'b0;
        if (sa == 0) begin
          e.ovf  = 1'b1;
          e.word = 16'hFFFF;
          sb.push_back(e);
          e.word = b;
          sb.push_back(e);
        end else if (sbv == -32768 && sa == -1) begin
          e.ovf  = 1'b1;
          e.word = 16'h8000;
          sb.push_back(e);
          e.word = 16'h0000;
          sb.push_back(e);
        end else begin
          r      = sbv / sa;
          e.word = r[15:0];
          sb.push_back(e);
          r      = sbv % sa;
          e.word = r[15:0];
          sb.push_back(e);
        end
      end
    endcase
  endfunction

  // Drives edge 0 (opcode, A) and edge 1 (B, scrambled start/s), returns between edges 1 and 2.
  task automatic drive_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    push_expected(op, a, b);
    @(negedge clk);
    start = 1'b1;
    s     = op;
    inbus = a;
    @(negedge clk);
    start = 1'($urandom_range(0, 1));
    s     = 2'($urandom);
    inbus = b;
    @(negedge clk);
    start = 1'b0;
    inbus = 16'($urandom);
  endtask

  task automatic wait_finish(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (finish === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    start = 1'b1;
    s     = MUL;
    inbus = 16'h1234;
    repeat (3) @(negedge clk);
    vectors++;
    if (outbus !== 16'h0 || finish !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL reset_state got outbus=%h finish=%b ovf=%b want 0000 0 0",
               outbus, finish, overflow);
      errors++;
    end
    start = 1'b0;
    rst_b = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (finish !== 1'b0 || outbus !== 16'h0) begin
      $display("FAIL reset_idle got outbus=%h finish=%b want 0000 0", outbus, finish);
      errors++;
    end
  endtask

  task automatic test_addsub();
    logic [1:0]  ov[6];
    logic [15:0] av[6];
    logic [15:0] bv[6];
    int          lat;
    exp_t        e;
    ov = '{ADD, SUB, SUB, ADD, ADD, SUB};
    av = '{16'd2147, 16'd5, 16'd1, 16'd16389, 16'($urandom), 16'($urandom)};
    bv = '{16'd5, 16'd2147, 16'h8000, 16'd16386, 16'($urandom), 16'($urandom)};
    for (int i = 0; i < 6; i++) begin
      drive_op(ov[i], av[i], bv[i]);
      wait_finish(lat);
      vectors++;
      if (lat != 2) begin
        $display("FAIL addsub_latency op=%0d a=%h b=%h got %0d want 2", ov[i], av[i], bv[i], lat);
        errors++;
        sb.delete();
      end else begin
        e = sb.pop_front();
        vectors++;
        if (outbus !== e.word || overflow !== e.ovf) begin
          $display("FAIL addsub_word op=%0d a=%h b=%h got outbus=%h ovf=%b want outbus=%h ovf=%b",
                   ov[i], av[i], bv[i], outbus, overflow, e.word, e.ovf);
          errors++;
        end
        @(negedge clk);
        vectors++;
        if (finish !== 1'b0 || outbus !== 16'h0 || overflow !== e.ovf) begin
          $display("FAIL addsub_after op=%0d got outbus=%h finish=%b ovf=%b want 0000 0 %b",
                   ov[i], outbus, finish, overflow, e.ovf);
          errors++;
        end
      end
    end
  endtask

  task automatic test_muldiv(input logic [1:0] op);
    logic [15:0] av[7];
    logic [15:0] bv[7];
    int          lat;
    int          want_lat;
    exp_t        e;
    if (op == MUL) begin
      av = '{16'd2350, 16'd2147, 16'hFFFD, 16'h8000, 16'h7FFF, 16'($urandom), 16'($urandom)};
      bv = '{16'd159, 16'd5, 16'd7, 16'h8000, 16'h8000, 16'($urandom), 16'($urandom)};
    end else begin
      av = '{16'd145, 16'd5, 16'd0, 16'hFFFF, 16'hFFF9, 16'd7, 16'($urandom)};
      bv = '{16'd18921, 16'd2147, 16'd1234, 16'h8000, 16'd100, 16'hFF9C, 16'($urandom)};
    end
    want_lat = (op == MUL) ? 17 : 18;
    for (int i = 0; i < 7; i++) begin
      drive_op(op, av[i], bv[i]);
      wait_finish(lat);
      vectors++;
      if (lat != want_lat) begin
        $display("FAIL muldiv_latency op=%0d a=%h b=%h got %0d want %0d",
                 op, av[i], bv[i], lat, want_lat);
        errors++;
        sb.delete();
      end else begin
        for (int k = 0; k < 2; k++) begin
          e = sb.pop_front();
          vectors++;
          if (finish !== 1'b1 || outbus !== e.word || overflow !== e.ovf) begin
            $display("FAIL muldiv_word%0d op=%0d a=%h b=%h got outbus=%h finish=%b ovf=%b want outbus=%h finish=1 ovf=%b",
                     k, op, av[i], bv[i], outbus, finish, overflow, e.word, e.ovf);
            errors++;
          end
          @(negedge clk);
        end
        vectors++;
        if (finish !== 1'b0 || outbus !== 16'h0 || overflow !== e.ovf) begin
          $display("FAIL muldiv_after op=%0d got outbus=%h finish=%b ovf=%b want 0000 0 %b",
                   op, outbus, finish, overflow, e.ovf);
          errors++;
        end
      end
    end
  endtask

  // start held high through the whole add: ignored while busy, then re-triggers at IDLE re-entry.
  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    push_expected(ADD, 16'd16389, 16'd16386);
    push_expected(SUB, 16'd300, 16'd1000);
    @(negedge clk);
    start = 1'b1;
    s     = ADD;
    inbus = 16'd16389;
    @(negedge clk);
    inbus = 16'd16386;
    s     = MUL;
    @(negedge clk);
    inbus = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    if (finish !== 1'b1 || outbus !== e.word || overflow !== e.ovf) begin
      $display("FAIL b2b_first got outbus=%h finish=%b ovf=%b want outbus=%h finish=1 ovf=%b",
               outbus, finish, overflow, e.word, e.ovf);
      errors++;
    end
    s     = SUB;
    inbus = 16'd300;
    @(negedge clk);
    vectors++;
    if (finish !== 1'b0 || outbus !== 16'h0 || overflow !== 1'b0) begin
      $display("FAIL b2b_restart got outbus=%h finish=%b ovf=%b want 0000 0 0",
               outbus, finish, overflow);
      errors++;
    end
    start = 1'b0;
    s     = DIV;
    inbus = 16'd1000;
    wait_finish(lat);
    vectors++;
    if (lat != 3) begin
      $display("FAIL b2b_latency got %0d want 3", lat);
      errors++;
      sb.delete();
    end else begin
      e = sb.pop_front();
      vectors++;
      if (outbus !== e.word || overflow !== e.ovf) begin
        $display("FAIL b2b_second got outbus=%h ovf=%b want outbus=%h ovf=%b",
                 outbus, overflow, e.word, e.ovf);
        errors++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int   seen;
    int   lat;
    exp_t e;
    drive_op(MUL, 16'd2350, 16'd159);
    repeat (6) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    sb.delete();
    vectors++;
    if (finish !== 1'b0 || outbus !== 16'h0 || overflow !== 1'b0) begin
      $display("FAIL rstmid_state got outbus=%h finish=%b ovf=%b want 0000 0 0",
               outbus, finish, overflow);
      errors++;
    end
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (finish !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      $display("FAIL rstmid_aborted got %0d finish cycles want 0", seen);
      errors++;
    end
    drive_op(ADD, 16'd2147, 16'd5);
    wait_finish(lat);
    vectors++;
    if (lat != 2) begin
      $display("FAIL rstmid_add_latency got %0d want 2", lat);
      errors++;
      sb.delete();
    end else begin
      e = sb.pop_front();
      vectors++;
      if (outbus !== e.word || overflow !== e.ovf) begin
        $display("FAIL rstmid_add got outbus=%h ovf=%b want outbus=%h ovf=%b",
                 outbus, overflow, e.word, e.ovf);
        errors++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_b = 1'b1;
    start = 1'b0;
    s     = 2'b00;
    inbus = 16'h0;
    test_reset();
    test_addsub();
    test_muldiv(MUL);
    test_muldiv(DIV);
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
